clk_pulse_gen: RTL and testbench

Synthesizable programmable pulse/clock generator clocked by the 100 MHz system clock `clk`. It produces a derived clock `clk_out` with programmable phase offset, high time and low time, all in whole `clk` cycles, for a programmed number of pulses or continuously. It is the RTL stage that drives the derived-clock consumers (`clk50`-style enables) in place of behavioural delay-based generation, and it is controlled by a start/stop/busy/done handshake.

---
 rtl/clk_pulse_pkg.sv | 19 +
 rtl/clk_pulse_gen_if.sv | 41 ++++
 rtl/clk_pulse_gen.sv | 134 +++++++++++++
 tb/tb_clk_pulse_gen.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_pulse_pkg.sv
// rtl/clk_pulse_pkg.sv - shared types and default widths for the pulse generator
//
// Purpose : state encoding and default counter widths used by clk_pulse_gen
//           and its control interface.
// Contents: pg_state_t (IDLE, PHASE, HIGH, LOW), PG_CNT_W, PG_NUM_W.

package clk_pulse_pkg;

  localparam int PG_CNT_W = 16;
  localparam int PG_NUM_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PHASE = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } pg_state_t;

endpackage

// File: rtl/clk_pulse_gen_if.sv
// rtl/clk_pulse_gen_if.sv - control/status bundle of the pulse generator
//
// Purpose : groups the start/stop handshake, run configuration and status
//           outputs of clk_pulse_gen into one bundle.
// Signals : start, stop                        - run request / abort
//           phase_cyc, ton_cyc, toff_cyc       - timing in clk cycles (CNT_W)
//           num_pulses                         - pulses per run, 0 = continuous
//           clk_out, busy, done, cfg_err       - generated clock and status
//           pulse_cnt                          - completed pulses (NUM_W)
// Modports: master drives control/config, slave (the generator) drives status.

interface clk_pulse_gen_if
  import clk_pulse_pkg::*;
#(
  parameter int CNT_W = PG_CNT_W,
  parameter int NUM_W = PG_NUM_W
) ();

  logic             start;
  logic             stop;
  logic [CNT_W-1:0] phase_cyc;
  logic [CNT_W-1:0] ton_cyc;
  logic [CNT_W-1:0] toff_cyc;
  logic [NUM_W-1:0] num_pulses;
  logic             clk_out;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic [NUM_W-1:0] pulse_cnt;

  modport master (
    output start, stop, phase_cyc, ton_cyc, toff_cyc, num_pulses,
    input  clk_out, busy, done, cfg_err, pulse_cnt
  );

  modport slave (
    input  start, stop, phase_cyc, ton_cyc, toff_cyc, num_pulses,
    output clk_out, busy, done, cfg_err, pulse_cnt
  );

endinterface

// File: rtl/clk_pulse_gen.sv
// rtl/clk_pulse_gen.sv - programmable derived-clock / pulse-train generator
//
// Purpose : produces a registered clock clk_out with programmable phase
//           offset, high time and low time (whole clk cycles), for a fixed
//           number of pulses or continuously, under a start/stop handshake.
// Ports   : clk   - system clock, rising edge
//           rst   - synchronous active-high reset
//           pg_if - clk_pulse_gen_if.slave: start/stop, phase_cyc, ton_cyc,
//                   toff_cyc, num_pulses in; clk_out, busy, done, cfg_err,
//                   pulse_cnt out

module clk_pulse_gen
  import clk_pulse_pkg::*;
#(
  parameter int CNT_W = PG_CNT_W,
  parameter int NUM_W = PG_NUM_W
) (
  input  logic                  clk,
  input  logic                  rst,
  clk_pulse_gen_if.slave        pg_if
);

  pg_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] ton_q;
  logic [CNT_W-1:0] toff_q;
  logic [NUM_W-1:0] num_q;
  logic [NUM_W-1:0] pulse_cnt_q;
  logic             clk_out_q;
  logic             busy_q;
  logic             done_q;
  logic             cfg_err_q;

  logic             cfg_ok_d;
  logic             cnt_zero_d;
  logic [NUM_W-1:0] pulse_cnt_d;
  logic             run_end_d;

  assign cfg_ok_d   = (pg_if.ton_cyc != '0) && (pg_if.toff_cyc != '0);
  assign cnt_zero_d = (cnt_q == '0);

  // Saturate instead of wrapping so a long continuous run never reports a
  // small count.
  assign pulse_cnt_d = (pulse_cnt_q == '1) ? pulse_cnt_q
                                           : pulse_cnt_q + NUM_W'(1);
  assign run_end_d   = (num_q != '0) && (pulse_cnt_d == num_q);

  // The phase offset is only needed at start acceptance (it goes straight
  // into the down-counter), so it is not kept in a separate register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ton_q       <= '0;
      toff_q      <= '0;
      num_q       <= '0;
      pulse_cnt_q <= '0;
      clk_out_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;

      if (state_q == IDLE) begin
        if (pg_if.start) begin
          if (cfg_ok_d) begin
            ton_q       <= pg_if.ton_cyc;
            toff_q      <= pg_if.toff_cyc;
            num_q       <= pg_if.num_pulses;
            pulse_cnt_q <= '0;
            busy_q      <= 1'b1;
            if (pg_if.phase_cyc == '0) begin
              state_q   <= HIGH;
              cnt_q     <= pg_if.ton_cyc - CNT_W'(1);
              clk_out_q <= 1'b1;
            end else begin
              state_q   <= PHASE;
              cnt_q     <= pg_if.phase_cyc - CNT_W'(1);
            end
          end else begin
            cfg_err_q <= 1'b1;
          end
        end
      end else if (pg_if.stop) begin
        // Abort: the partial pulse is dropped, pulse_cnt keeps its value.
        state_q   <= IDLE;
        clk_out_q <= 1'b0;
        busy_q    <= 1'b0;
        done_q    <= 1'b1;
      end else if (!cnt_zero_d) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end else begin
        // Counter expired: leave the current state, reloading the counter
        // with (field - 1) for the state being entered.
        case (state_q)
          PHASE: begin
            state_q   <= HIGH;
            cnt_q     <= ton_q - CNT_W'(1);
            clk_out_q <= 1'b1;
          end
          HIGH: begin
            state_q   <= LOW;
            cnt_q     <= toff_q - CNT_W'(1);
            clk_out_q <= 1'b0;
          end
          LOW: begin
            pulse_cnt_q <= pulse_cnt_d;
            if (run_end_d) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q   <= HIGH;
              cnt_q     <= ton_q - CNT_W'(1);
              clk_out_q <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign pg_if.clk_out   = clk_out_q;
  assign pg_if.busy      = busy_q;
  assign pg_if.done      = done_q;
  assign pg_if.cfg_err   = cfg_err_q;
  assign pg_if.pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_clk_pulse_gen.sv
// tb/tb_clk_pulse_gen.sv - directed self-checking bench for clk_pulse_gen

module tb_clk_pulse_gen;

  localparam int CNT_W = 16;
  localparam int NUM_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  clk_pulse_gen_if #(.CNT_W(CNT_W), .NUM_W(NUM_W)) pg_if ();

  clk_pulse_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .pg_if (pg_if)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int ph, input int ton, input int toff, input int n);
    pg_if.phase_cyc  = CNT_W'(ph);
    pg_if.ton_cyc    = CNT_W'(ton);
    pg_if.toff_cyc   = CNT_W'(toff);
    pg_if.num_pulses = NUM_W'(n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({pg_if.clk_out, pg_if.busy, pg_if.done, pg_if.cfg_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000",
               {pg_if.clk_out, pg_if.busy, pg_if.done, pg_if.cfg_err});
    end
    checks++;
    if (pg_if.pulse_cnt !== '0) begin
      errors++;
      $display("FAIL reset_pulse_cnt: got %0d want 0", pg_if.pulse_cnt);
    end
    rst = 1'b0;
    step();
  endtask

  // Accepts a run at E0 and checks every cycle k (after edge E0+k) up to the
  // run end at k = ph + n*(ton+toff). Config inputs are scrambled after
  // acceptance to confirm they were latched.
  task automatic test_counted_run(input string name, input int ph, input int ton,
                                  input int toff, input int n);
    int   p;
    int   e;
    logic exp_clk;
    logic exp_busy;
    logic exp_done;
    int   exp_cnt;
    p = ton + toff;
    e = ph + n * p;
    set_cfg(ph, ton, toff, n);
    pg_if.start = 1'b1;
    step();
    pg_if.start = 1'b0;
    set_cfg(7, 0, 3, 1);
    for (int k = 0; k <= e; k++) begin
      exp_clk  = (k >= ph) && (k < e) && (((k - ph) % p) < ton);
      exp_busy = (k < e);
      exp_done = (k == e);
      exp_cnt  = (k < ph) ? 0 : (k - ph) / p;
      checks++;
      if (pg_if.clk_out !== exp_clk) begin
        errors++;
        $display("FAIL %s clk_out k=%0d: got %b want %b", name, k, pg_if.clk_out, exp_clk);
      end
      checks++;
      if (pg_if.busy !== exp_busy) begin
        errors++;
        $display("FAIL %s busy k=%0d: got %b want %b", name, k, pg_if.busy, exp_busy);
      end
      checks++;
      if (pg_if.done !== exp_done) begin
        errors++;
        $display("FAIL %s done k=%0d: got %b want %b", name, k, pg_if.done, exp_done);
      end
      checks++;
      if (pg_if.pulse_cnt !== NUM_W'(exp_cnt)) begin
        errors++;
        $display("FAIL %s pulse_cnt k=%0d: got %0d want %0d", name, k, pg_if.pulse_cnt, exp_cnt);
      end
      if (k < e) step();
    end
    step();
    checks++;
    if ({pg_if.done, pg_if.busy, pg_if.clk_out} !== 3'b000) begin
      errors++;
      $display("FAIL %s after_end done/busy/clk: got %b want 000", name,
               {pg_if.done, pg_if.busy, pg_if.clk_out});
    end
  endtask

  task automatic test_cfg_err();
    for (int i = 0; i < 2; i++) begin
      if (i == 0) set_cfg(2, 0, 4, 1);
      else        set_cfg(2, 4, 0, 1);
      pg_if.start = 1'b1;
      step();
      pg_if.start = 1'b0;
      checks++;
      if (pg_if.cfg_err !== 1'b1) begin
        errors++;
        $display("FAIL cfg_err_pulse case %0d: got %b want 1", i, pg_if.cfg_err);
      end
      checks++;
      if ({pg_if.busy, pg_if.clk_out, pg_if.done} !== 3'b000) begin
        errors++;
        $display("FAIL cfg_err_status case %0d: got %b want 000", i,
                 {pg_if.busy, pg_if.clk_out, pg_if.done});
      end
      step();
      checks++;
      if ({pg_if.cfg_err, pg_if.busy} !== 2'b00) begin
        errors++;
        $display("FAIL cfg_err_clear case %0d: got %b want 00", i, {pg_if.cfg_err, pg_if.busy});
      end
    end
  endtask

  // Continuous run, phase 1, ton 3, toff 4 (P=7). Pulse 5 is high for
  // k = 29..31; stop is raised in cycle 30.
  task automatic test_stop_continuous();
    logic exp_clk;
    set_cfg(1, 3, 4, 0);
    pg_if.start = 1'b1;
    step();
    pg_if.start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      exp_clk = (k >= 1) && (((k - 1) % 7) < 3);
      checks++;
      if (pg_if.clk_out !== exp_clk) begin
        errors++;
        $display("FAIL cont clk_out k=%0d: got %b want %b", k, pg_if.clk_out, exp_clk);
      end
      step();
    end
    checks++;
    if ({pg_if.clk_out, pg_if.busy} !== 2'b11 || pg_if.pulse_cnt !== NUM_W'(4)) begin
      errors++;
      $display("FAIL cont before_stop clk/busy/cnt: got %b %0d want 11 4",
               {pg_if.clk_out, pg_if.busy}, pg_if.pulse_cnt);
    end
    pg_if.stop = 1'b1;
    step();
    pg_if.stop = 1'b0;
    checks++;
    if ({pg_if.clk_out, pg_if.busy, pg_if.done} !== 3'b001) begin
      errors++;
      $display("FAIL stop clk/busy/done: got %b want 001", {pg_if.clk_out, pg_if.busy, pg_if.done});
    end
    checks++;
    if (pg_if.pulse_cnt !== NUM_W'(4)) begin
      errors++;
      $display("FAIL stop pulse_cnt: got %0d want 4", pg_if.pulse_cnt);
    end
    step();
    checks++;
    if ({pg_if.clk_out, pg_if.done} !== 2'b00 || pg_if.pulse_cnt !== NUM_W'(4)) begin
      errors++;
      $display("FAIL after_stop clk/done/cnt: got %b %0d want 00 4",
               {pg_if.clk_out, pg_if.done}, pg_if.pulse_cnt);
    end
    pg_if.stop = 1'b1;
    step();
    pg_if.stop = 1'b0;
    checks++;
    if ({pg_if.done, pg_if.busy} !== 2'b00) begin
      errors++;
      $display("FAIL idle_stop done/busy: got %b want 00", {pg_if.done, pg_if.busy});
    end
  endtask

  // Run 1: ph 1, ton 2, toff 2, n 2 -> ends at k=9. A start with ton=0 in
  // cycle 3 must be ignored. Run 2 (ph 2, ton 1, toff 1, n 1) is requested
  // in the done cycle: rise at k'=2, done at k'=4.
  task automatic test_back_to_back();
    logic exp_clk;
    set_cfg(1, 2, 2, 2);
    pg_if.start = 1'b1;
    step();
    pg_if.start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      exp_clk = (k >= 1) && (((k - 1) % 4) < 2);
      checks++;
      if (pg_if.clk_out !== exp_clk || pg_if.cfg_err !== 1'b0 || pg_if.busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b run1 k=%0d clk/cfg_err/busy: got %b%b%b want %b01", k,
                 pg_if.clk_out, pg_if.cfg_err, pg_if.busy, exp_clk);
      end
      pg_if.start = (k == 3);
      if (k == 3) set_cfg(0, 0, 1, 1);
      step();
    end
    pg_if.start = 1'b0;
    checks++;
    if ({pg_if.done, pg_if.busy} !== 2'b10 || pg_if.pulse_cnt !== NUM_W'(2)) begin
      errors++;
      $display("FAIL b2b run1 end done/busy/cnt: got %b %0d want 10 2",
               {pg_if.done, pg_if.busy}, pg_if.pulse_cnt);
    end
    set_cfg(2, 1, 1, 1);
    pg_if.start = 1'b1;
    step();
    pg_if.start = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      exp_clk = (k == 2);
      checks++;
      if (pg_if.clk_out !== exp_clk || pg_if.busy !== (k < 4) || pg_if.done !== (k == 4)) begin
        errors++;
        $display("FAIL b2b run2 k=%0d clk/busy/done: got %b%b%b want %b%b%b", k,
                 pg_if.clk_out, pg_if.busy, pg_if.done, exp_clk, (k < 4), (k == 4));
      end
      if (k < 4) step();
    end
    checks++;
    if (pg_if.pulse_cnt !== NUM_W'(1)) begin
      errors++;
      $display("FAIL b2b run2 pulse_cnt: got %0d want 1", pg_if.pulse_cnt);
    end
    step();
  endtask

  // ph 0, ton 2, toff 5, n 3: cycle 4 is inside the first LOW.
  task automatic test_reset_mid_low();
    set_cfg(0, 2, 5, 3);
    pg_if.start = 1'b1;
    step();
    pg_if.start = 1'b0;
    repeat (4) step();
    checks++;
    if ({pg_if.busy, pg_if.clk_out} !== 2'b10) begin
      errors++;
      $display("FAIL mid_low busy/clk: got %b want 10", {pg_if.busy, pg_if.clk_out});
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({pg_if.clk_out, pg_if.busy, pg_if.done, pg_if.cfg_err} !== 4'b0000 ||
        pg_if.pulse_cnt !== '0) begin
      errors++;
      $display("FAIL reset_mid_low outputs: got %b %0d want 0000 0",
               {pg_if.clk_out, pg_if.busy, pg_if.done, pg_if.cfg_err}, pg_if.pulse_cnt);
    end
    step();
    checks++;
    if ({pg_if.done, pg_if.busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_low no_done: got %b want 00", {pg_if.done, pg_if.busy});
    end
    test_counted_run("after_rst", 1, 1, 1, 2);
  endtask

  initial begin
    pg_if.start = 1'b0;
    pg_if.stop  = 1'b0;
    set_cfg(0, 0, 0, 0);
    test_reset();
    test_counted_run("duty10", 2, 1, 9, 10);
    test_counted_run("duty50", 0, 5, 5, 3);
    test_cfg_err();
    test_stop_continuous();
    test_back_to_back();
    test_reset_mid_low();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
